led_mode_seq: RTL and testbench
===============================

# led_mode_seq

Parametrised LED pattern sequencer driven by a single raw push-button. It synchronises and debounces the button, advances a mode register on each clean press, and animates the selected pattern on `LED_W` outputs at a prescaled rate. It supersedes the fixed 4-LED lab mode FSM and adds width and mode-count parameters, debouncing, animated patterns and a freeze control. It sits between the board button/clock pins and the LED bank.

## Interface
- `LED_W`, 4: number of LED outputs, ≥2.
- `NUM_MODES`, 6: modes in use, 2..6; the mode wraps from `NUM_MODES-1` to 0.
- `DEBOUNCE_CYC`, 2: consecutive synchronised samples needed to accept a level change, ≥1.
- `TICK_DIV`, 8: clock cycles per animation step, ≥2.

Ports:
- `clk` in 1: sole clock, rising edge.
- `clr` in 1: reset, synchronous, active-high.
- `mode_ext` in 1: raw button, asynchronous, active-high.
- `hold` in 1: freezes animation (prescaler and pattern) while high; synchronous, no debounce.
- `led` out `LED_W`: registered pattern output.
- `mode` out 3: current mode index.

## Operation
- Synchroniser: 2 flops `s1`→`s2`.
- Debounce:
  - Counter `cnt` increments while `s2 != db`.
  - When `s2 != db` and `cnt == DEBOUNCE_CYC-1`: `db <= s2` and `cnt <= 0`.
  - When `s2 == db`: `cnt <= 0`.
  - A glitch shorter than `DEBOUNCE_CYC` samples is ignored.
- Press: the edge where `db` goes 0→1. On that edge `mode <= (mode == NUM_MODES-1) ? 0 : mode+1`.
  - Holding the button gives no auto-repeat.
  - Release (1→0) has no effect.
- Modes and their values (load value = LED state when the mode is entered; step = LED update each tick):
  - 0 OFF: load 0, static.
  - 1 ON: load all ones, static.
  - 2 WALK_L: load 1, step rotates left (MSB→bit0).
  - 3 WALK_R: load `1<<(LED_W-1)`, step rotates right.
  - 4 COUNT: load 0, step `led+1`, wraps mod 2^`LED_W`.
  - 5 BLINK: load all ones, step bitwise invert.
- Prescaler `pcnt`:
  - Counts 0..`TICK_DIV-1` while `hold`=0.
  - `tick` = (`pcnt == TICK_DIV-1`) & ~`hold`.
  - On tick, `led` takes the step value.
- On the press edge:
  - `pcnt <= 0`.
  - `led <=` load value of the new mode.
  - The press wins over a coincident tick.
  - The press is honoured even while `hold`=1.

## Timing
- Reset: `s1`, `s2`, `db`, `cnt`, `pcnt` = 0; `mode` = 0; `led` = 0 (OFF).
- `clr` mid-debounce or mid-animation discards all state at that edge. A button still held after `clr` is released counts as a new press once debounced.
- Press latency: if `mode_ext` is first sampled high at edge E0 and stays high, `mode` and `led` update at edge E0+`DEBOUNCE_CYC`+1.
- Minimum accepted press: `DEBOUNCE_CYC` sampling edges high. The same minimum applies low between presses.
- First animation step after a press lands `TICK_DIV` edges after the press edge. Steps then repeat every `TICK_DIV` edges.
- `hold`:
  - Rising at edge H: no tick from edge H onward; `pcnt` keeps its value.
  - After `hold` falls, counting resumes from the held `pcnt`.
- Outputs are purely registered; there is no combinational path from input to output.

## Structure
- Package `led_seq_pkg`:
  - Mode localparams `M_OFF`..`M_BLINK` (3-bit).
  - Function `load_pat(mode, LED_W)`.
  - Function `step_pat(mode, cur)`.
- Sub-module `btn_debounce` (params `DEBOUNCE_CYC`; ports `clk`, `clr`, `raw`, `level`, `press`) holds the synchroniser, debounce counter and rise-pulse.
- The top holds the mode register, prescaler and pattern register.

## Test plan
All scenarios use `LED_W`=4, `NUM_MODES`=6, `DEBOUNCE_CYC`=2, `TICK_DIV`=4, 10 ns clock.
- Reset: assert `clr` 2 cycles with `mode_ext`=1 → `led`=0000, `mode`=0. After release, one press is registered (`mode`=1, `led`=1111).
- Six 20 ns presses separated by 20 ns → `mode` steps 1,2,3,4,5,0. Each change lands at E0+3.
- Glitch: a 10 ns (one sample) high pulse → `mode` and `led` unchanged.
- WALK_L: enter mode 2 → `led`=0001, then 0010, 0100, 1000, 0001 at 4-cycle intervals.
- COUNT with `hold`:
  - Enter mode 4 → `led` 0000→0001→0010.
  - Raise `hold` for 12 cycles → `led` stays 0010.
  - Release `hold` → `led`=0011 after the remaining prescale cycles.
- Coincidence: a press edge on a tick edge in BLINK → `led`=1111 (new-mode load value), `pcnt`=0.

Source files
------------

// File: rtl/led_seq_pkg.sv
// led_seq_pkg
//   Shared definitions for the LED mode sequencer: mode encodings and the
//   pattern helpers that give each mode's load value and per-tick step.
//   Patterns are carried in a 32-bit container and masked to the live LED
//   width, so callers truncate the result to their own LED_W (max 32).
package led_seq_pkg;

    localparam int LED_W_MAX = 32;

    localparam logic [2:0] M_OFF    = 3'd0;
    localparam logic [2:0] M_ON     = 3'd1;
    localparam logic [2:0] M_WALK_L = 3'd2;
    localparam logic [2:0] M_WALK_R = 3'd3;
    localparam logic [2:0] M_COUNT  = 3'd4;
    localparam logic [2:0] M_BLINK  = 3'd5;

    typedef logic [LED_W_MAX-1:0] pat_t;

    // Ones in the low led_w bits.
    function automatic pat_t width_mask(input int led_w);
        pat_t m;
        m = '0;
        for (int i = 0; i < LED_W_MAX; i++)
            if (i < led_w) m[i] = 1'b1;
        return m;
    endfunction

    // LED state presented on entry to a mode.
    function automatic pat_t load_pat(input logic [2:0] mode, input int led_w);
        pat_t p;
        case (mode)
            M_ON, M_BLINK: p = width_mask(led_w);
            M_WALK_L:      p = pat_t'(1);
            M_WALK_R:      p = pat_t'(1) << (led_w - 1);
            default:       p = '0;
        endcase
        return p;
    endfunction

    // LED state after one animation tick. The rotations wrap inside led_w
    // bits, which is why the width has to travel with the pattern.
    function automatic pat_t step_pat(input logic [2:0] mode, input pat_t cur,
                                      input int led_w);
        pat_t m;
        pat_t c;
        pat_t p;
        m = width_mask(led_w);
        c = cur & m;
        case (mode)
            M_WALK_L: p = ((c << 1) | (c >> (led_w - 1))) & m;
            M_WALK_R: p = ((c >> 1) | (c << (led_w - 1))) & m;
            M_COUNT:  p = (c + pat_t'(1)) & m;
            M_BLINK:  p = ~c & m;
            default:  p = c;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
//   Two-flop synchroniser plus counting debouncer for a raw push-button.
//   Ports:
//     clk   in  clock, rising edge
//     clr   in  synchronous active-high reset
//     raw   in  asynchronous button level
//     level out debounced level
//     press out one-cycle pulse, high during the cycle whose closing edge
//               flips level 0->1 (so consumers update on that same edge)
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic          r_s1;
    logic          r_s2;
    logic          r_db;
    logic [CW-1:0] r_cnt;

    logic w_last;
    assign w_last = (r_cnt == CW'(DEBOUNCE_CYC - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= raw;
            r_s2 <= r_s1;
            if (r_s2 != r_db) begin
                if (w_last) begin
                    r_db  <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_db;
    // Decoded from the accept condition rather than a delayed copy of r_db,
    // so the mode register moves on the same edge as the debounced level.
    assign press = r_s2 & ~r_db & w_last;

endmodule

// File: rtl/led_mode_seq.sv
// led_mode_seq
//   Button-driven LED pattern sequencer. Each clean press advances the mode
//   (wrapping at NUM_MODES) and reloads the pattern; a prescaler steps the
//   pattern every TICK_DIV cycles unless hold is high.
//   Ports:
//     clk      in  clock, rising edge
//     clr      in  synchronous active-high reset
//     mode_ext in  raw asynchronous push-button
//     hold     in  freezes prescaler and pattern while high
//     led      out registered LED pattern, LED_W bits
//     mode     out current mode index, 3 bits
module led_mode_seq
    import led_seq_pkg::*;
#(
    parameter int LED_W        = 4,
    parameter int NUM_MODES    = 6,
    parameter int DEBOUNCE_CYC = 2,
    parameter int TICK_DIV     = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             mode_ext,
    input  logic             hold,
    output logic [LED_W-1:0] led,
    output logic [2:0]       mode
);

    localparam int PW = $clog2(TICK_DIV);

    logic             w_press;
    logic             w_level_unused;  // only the press pulse matters here
    logic             w_tick;
    logic [2:0]       w_next_mode;

    logic [2:0]       r_mode;
    logic [PW-1:0]    r_pcnt;
    logic [LED_W-1:0] r_led;

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn (
        .clk  (clk),
        .clr  (clr),
        .raw  (mode_ext),
        .level(w_level_unused),
        .press(w_press)
    );

    assign w_tick      = (r_pcnt == PW'(TICK_DIV - 1)) & ~hold;
    assign w_next_mode = (r_mode == 3'(NUM_MODES - 1)) ? 3'd0 : r_mode + 3'd1;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_mode <= M_OFF;
            r_pcnt <= '0;
            r_led  <= '0;
        end else if (w_press) begin
            // Press beats a coincident tick and ignores hold.
            r_mode <= w_next_mode;
            r_pcnt <= '0;
            r_led  <= LED_W'(load_pat(w_next_mode, LED_W));
        end else if (!hold) begin
            r_pcnt <= w_tick ? '0 : r_pcnt + PW'(1);
            if (w_tick)
                r_led <= LED_W'(step_pat(r_mode, pat_t'(r_led), LED_W));
        end
    end

    assign led  = r_led;
    assign mode = r_mode;

endmodule

// File: tb/tb_led_mode_seq.sv
module tb_led_mode_seq;

    localparam int LW = 4;
    localparam int NM = 6;
    localparam int DC = 2;
    localparam int TD = 4;

    logic          clk;
    logic          clr;
    logic          mode_ext;
    logic          hold;
    logic [LW-1:0] led;
    logic [2:0]    mode;

    int vecs = 0;
    int errs = 0;

    led_mode_seq #(
        .LED_W(LW), .NUM_MODES(NM), .DEBOUNCE_CYC(DC), .TICK_DIV(TD)
    ) dut (
        .clk(clk), .clr(clr), .mode_ext(mode_ext), .hold(hold),
        .led(led), .mode(mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Button: raw samples reach the debouncer two edges late; the level
    // flips once the last DC delivered samples all disagree with it.
    // Pattern: counts un-held edges since the last press; every TD of them
    // is a step, computed arithmetically on the pattern value.
    int unsigned m_mode, m_led, m_run;
    bit          m_level, m_ok;
    bit          dly[$];
    bit          win[$];

    function automatic int unsigned m_load(input int unsigned md);
        int unsigned full;
        full = 1 << LW;
        case (md)
            1, 5:    return full - 1;
            2:       return 1;
            3:       return full / 2;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned m_step(input int unsigned md, input int unsigned cur);
        int unsigned full;
        full = 1 << LW;
        case (md)
            2:       return (cur * 2) % full + cur / (full / 2);
            3:       return cur / 2 + (cur % 2) * (full / 2);
            4:       return (cur + 1) % full;
            5:       return (full - 1) - cur;
            default: return cur;
        endcase
    endfunction

    always @(posedge clk) begin
        bit smp;
        bit flip;
        if (clr) begin
            m_mode = 0; m_led = 0; m_run = 0; m_level = 0; m_ok = 1;
            dly = '{1'b0, 1'b0};
            win.delete();
        end else if (m_ok) begin
            smp = dly.pop_front();
            dly.push_back(mode_ext);
            win.push_back(smp);
            if (win.size() > DC) void'(win.pop_front());
            flip = (win.size() == DC);
            foreach (win[i]) if (win[i] == m_level) flip = 0;
            if (flip) m_level = ~m_level;
            if (flip && m_level) begin
                m_mode = (m_mode + 1) % NM;
                m_led  = m_load(m_mode);
                m_run  = 0;
            end else if (!hold) begin
                m_run++;
                if (m_run == TD) begin
                    m_run = 0;
                    m_led = m_step(m_mode, m_led);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            vecs++;
            if (led !== LW'(m_led) || mode !== 3'(m_mode)) begin
                errs++;
                $display("FAIL model_cmp t=%0t: led=%b mode=%0d, expected led=%b mode=%0d",
                         $time, led, mode, LW'(m_led), m_mode);
            end
        end
    end

    // ---------------- directed literal checks ----------------
    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // 2-sample high, 2-sample low press; returns just after edge E0+3.
    task automatic press(input int em, input int el);
        mode_ext = 1'b1;
        cyc(2);
        mode_ext = 1'b0;
        cyc(1);
        chk("press_not_early", int'(mode), (em + NM - 1) % NM);
        cyc(1);
        chk("press_mode", int'(mode), em);
        chk("press_led", int'(led), el);
    endtask

    initial begin
        clr = 1'b1; mode_ext = 1'b1; hold = 1'b0;
        m_ok = 0;

        // reset with button held
        cyc(2);
        chk("reset_led", int'(led), 0);
        chk("reset_mode", int'(mode), 0);
        clr = 1'b0;
        cyc(3);
        chk("post_clr_latency", int'(mode), 0);
        cyc(1);
        chk("post_clr_mode", int'(mode), 1);
        chk("post_clr_led", int'(led), 15);
        mode_ext = 1'b0;
        cyc(4);
        clr = 1'b1; cyc(1); clr = 1'b0; cyc(2);

        // six presses: 1..5 then wrap; 6th lands on a BLINK tick edge
        press(1, 15); press(2, 1); press(3, 8);
        press(4, 0);  press(5, 15); press(0, 0);

        // one-sample glitch is ignored
        mode_ext = 1'b1; cyc(1); mode_ext = 1'b0;
        cyc(6);
        chk("glitch_mode", int'(mode), 0);
        chk("glitch_led", int'(led), 0);

        // WALK_L animation
        press(1, 15); press(2, 1);
        cyc(4); chk("walk_l_1", int'(led), 2);
        cyc(4); chk("walk_l_2", int'(led), 4);
        cyc(4); chk("walk_l_3", int'(led), 8);
        cyc(4); chk("walk_l_4", int'(led), 1);

        // COUNT with hold
        press(3, 8); press(4, 0);
        cyc(4); chk("count_1", int'(led), 1);
        cyc(4); chk("count_2", int'(led), 2);
        cyc(1);
        hold = 1'b1; cyc(12);
        chk("hold_frozen", int'(led), 2);
        hold = 1'b0;
        cyc(2); chk("hold_resume_early", int'(led), 2);
        cyc(1); chk("hold_resume", int'(led), 3);

        // press lands on a tick edge: load value wins, prescaler restarts
        press(5, 15);
        cyc(3); chk("coinc_no_early_step", int'(led), 15);
        cyc(1); chk("coinc_first_step", int'(led), 0);

        // clr mid-debounce with the button still held
        mode_ext = 1'b1; cyc(2);
        clr = 1'b1; cyc(1);
        chk("clr_mid_mode", int'(mode), 0);
        chk("clr_mid_led", int'(led), 0);
        clr = 1'b0;
        cyc(3); chk("clr_mid_repress_early", int'(mode), 0);
        cyc(1); chk("clr_mid_repress", int'(mode), 1);
        mode_ext = 1'b0; cyc(4);

        // press honoured while hold is high
        hold = 1'b1;
        press(2, 1);
        cyc(6); chk("hold_press_static", int'(led), 1);
        hold = 1'b0;
        cyc(8);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
